// File: rtl/event_rr_arbiter.sv
// event_rr_arbiter
//   Round-robin arbiter that shares one registered event channel (valid/ready)
//   between NUM_PIX pixel requesters. Each pixel presents a 2-bit polarity
//   request (2'b10 = ON, 2'b01 = OFF, 2'b00 = idle, 2'b11 = illegal). A granted
//   request becomes an event {addr, pol} and a one-cycle ack pulse returns to
//   the granted pixel so it can clear its request.
//
// Optional feature: define EVT_TIMESTAMP_EN to add a free-running TS_W-bit
//   counter and the evt_ts_o port (counter value captured on the grant edge).
//
// Ports
//   clk_i        in   clock, rising edge
//   reset_i      in   synchronous, active-low reset
//   req_i        in   pixel k request = req_i[2k+1:2k]
//   ack_o        out  one-hot, single-cycle ack to the granted pixel
//   evt_valid_o  out  event valid
//   evt_ready_i  in   downstream ready
//   evt_addr_o   out  granted pixel index
//   evt_pol_o    out  1 = ON, 0 = OFF
//   evt_ts_o     out  event timestamp (EVT_TIMESTAMP_EN only)
//   err_o        out  sticky: some pixel presented 2'b11
module event_rr_arbiter #(
  parameter int unsigned NUM_PIX  = 16,
  parameter int unsigned POLARITY = 2,
`ifdef EVT_TIMESTAMP_EN
  parameter int unsigned TS_W     = 16,
`endif
  localparam int unsigned ADDR_W  = $clog2(NUM_PIX)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_PIX*POLARITY-1:0]  req_i,
  output logic [NUM_PIX-1:0]           ack_o,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [ADDR_W-1:0]            evt_addr_o,
  output logic                         evt_pol_o,
`ifdef EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]              evt_ts_o,
`endif
  output logic                         err_o
);

  typedef enum logic {
    IDLE,
    VALID
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   rr_ptr;
  logic [ADDR_W-1:0]   sel;
  logic [ADDR_W-1:0]   rr_next;
  logic                found;
  logic                load;
  logic [NUM_PIX-1:0]  legal;
  logic [NUM_PIX-1:0]  illegal;
  logic [NUM_PIX-1:0]  pol_bit;
  logic [NUM_PIX-1:0]  eligible;

  // Per-pixel request decode.
  always_comb begin
    legal   = '0;
    illegal = '0;
    pol_bit = '0;
    for (int unsigned k = 0; k < NUM_PIX; k++) begin
      legal[k]   = req_i[k*POLARITY+1] ^ req_i[k*POLARITY];
      illegal[k] = req_i[k*POLARITY+1] & req_i[k*POLARITY];
      pol_bit[k] = req_i[k*POLARITY+1];
    end
  end

  // The pixel being acked this cycle may still show its old request; masking
  // it with the registered ack prevents a double grant.
  assign eligible = legal & ~ack_o;

  // First eligible index scanning rr_ptr upwards, wrapping modulo NUM_PIX.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_PIX; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_PIX) idx = idx - NUM_PIX;
      if (!found && eligible[ADDR_W'(idx)]) begin
        found = 1'b1;
        sel   = ADDR_W'(idx);
      end
    end
  end

  assign rr_next = (sel == ADDR_W'(NUM_PIX - 1)) ? '0 : sel + 1'b1;

  // Next-state / load decision.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load       = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (evt_ready_i) begin
          if (found) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign evt_valid_o = (state == VALID);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rr_ptr     <= '0;
      ack_o      <= '0;
      evt_addr_o <= '0;
      evt_pol_o  <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ack_o <= '0;
      err_o <= err_o | (|illegal);
      if (load) begin
        ack_o      <= NUM_PIX'(1) << sel;
        evt_addr_o <= sel;
        evt_pol_o  <= pol_bit[sel];
        rr_ptr     <= rr_next;
      end
    end
  end

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ts_cnt   <= '0;
      evt_ts_o <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (load) begin
        evt_ts_o <= ts_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_event_rr_arbiter.sv
// Directed testbench for event_rr_arbiter (NUM_PIX = 16).
module tb_event_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] req;
  logic [15:0] ack;
  logic        valid;
  logic        ready;
  logic [3:0]  addr;
  logic        pol;
  logic        err;
`ifdef EVT_TIMESTAMP_EN
  logic [3:0]  ts;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  event_rr_arbiter #(
    .NUM_PIX  (16),
    .POLARITY (2)
`ifdef EVT_TIMESTAMP_EN
    , .TS_W   (4)
`endif
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_n),
    .req_i       (req),
    .ack_o       (ack),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_addr_o  (addr),
    .evt_pol_o   (pol),
`ifdef EVT_TIMESTAMP_EN
    .evt_ts_o    (ts),
`endif
    .err_o       (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int k, input logic [1:0] v);
    req[2*k +: 2] = v;
  endtask

  task automatic do_reset();
    req     = '0;
    ready   = 1'b1;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req     = {16{2'b10}};
    ready   = 1'b1;
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%0b exp=0", c, valid); end
      checks++; if (ack !== 16'h0000) begin failures++; $display("FAIL reset_ack cyc=%0d got=%h exp=0000", c, ack); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err cyc=%0d got=%0b exp=0", c, err); end
      checks++; if (addr !== 4'd0) begin failures++; $display("FAIL reset_addr cyc=%0d got=%0d exp=0", c, addr); end
    end
    reset_n = 1'b1;
    step();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL reset_first_valid got=%0b exp=1", valid); end
    checks++; if (addr !== 4'd0) begin failures++; $display("FAIL reset_first_addr got=%0d exp=0", addr); end
    checks++; if (pol !== 1'b1) begin failures++; $display("FAIL reset_first_pol got=%0b exp=1", pol); end
    checks++; if (ack !== 16'h0001) begin failures++; $display("FAIL reset_first_ack got=%h exp=0001", ack); end
  endtask

  task automatic test_single();
    do_reset();
    set_pix(5, 2'b01);
    step();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", valid); end
    checks++; if (addr !== 4'd5) begin failures++; $display("FAIL single_addr got=%0d exp=5", addr); end
    checks++; if (pol !== 1'b0) begin failures++; $display("FAIL single_pol got=%0b exp=0", pol); end
    checks++; if (ack !== 16'h0020) begin failures++; $display("FAIL single_ack got=%h exp=0020", ack); end
    set_pix(5, 2'b00);
    step();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_drop_valid got=%0b exp=0", valid); end
    checks++; if (ack !== 16'h0000) begin failures++; $display("FAIL single_drop_ack got=%h exp=0000", ack); end
    step();
    checks++; if (addr !== 4'd5) begin failures++; $display("FAIL single_idle_addr_hold got=%0d exp=5", addr); end
  endtask

  task automatic test_round_robin();
    int exp_addr[7] = '{2, 7, 15, 2, 7, 15, 2};
    do_reset();
    set_pix(2, 2'b10);
    set_pix(7, 2'b10);
    set_pix(15, 2'b10);
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL rr_valid n=%0d got=%0b exp=1", i, valid); end
      checks++; if (addr !== 4'(exp_addr[i])) begin failures++; $display("FAIL rr_addr n=%0d got=%0d exp=%0d", i, addr, exp_addr[i]); end
      checks++; if (ack !== (16'h0001 << exp_addr[i])) begin failures++; $display("FAIL rr_ack n=%0d got=%h exp=%h", i, ack, 16'h0001 << exp_addr[i]); end
      checks++; if (pol !== 1'b1) begin failures++; $display("FAIL rr_pol n=%0d got=%0b exp=1", i, pol); end
    end
    req = '0;
    step();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rr_end_valid got=%0b exp=0", valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    set_pix(3, 2'b10);
    set_pix(4, 2'b10);
    step();
    checks++; if (addr !== 4'd3) begin failures++; $display("FAIL bp_first_addr got=%0d exp=3", addr); end
    checks++; if (ack !== 16'h0008) begin failures++; $display("FAIL bp_first_ack got=%h exp=0008", ack); end
    set_pix(3, 2'b00);
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", c, valid); end
      checks++; if (addr !== 4'd3) begin failures++; $display("FAIL bp_hold_addr cyc=%0d got=%0d exp=3", c, addr); end
      checks++; if (ack !== 16'h0000) begin failures++; $display("FAIL bp_hold_ack cyc=%0d got=%h exp=0000", c, ack); end
    end
    ready = 1'b1;
    step();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%0b exp=1", valid); end
    checks++; if (addr !== 4'd4) begin failures++; $display("FAIL bp_next_addr got=%0d exp=4", addr); end
    checks++; if (ack !== 16'h0010) begin failures++; $display("FAIL bp_next_ack got=%h exp=0010", ack); end
    set_pix(4, 2'b00);
    step();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%0b exp=0", valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    set_pix(9, 2'b11);
    set_pix(10, 2'b10);
    step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err got=%0b exp=1", err); end
    checks++; if (addr !== 4'd10) begin failures++; $display("FAIL ill_addr got=%0d exp=10", addr); end
    checks++; if (pol !== 1'b1) begin failures++; $display("FAIL ill_pol got=%0b exp=1", pol); end
    checks++; if (ack !== 16'h0400) begin failures++; $display("FAIL ill_ack got=%h exp=0400", ack); end
    set_pix(10, 2'b00);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ill_valid cyc=%0d got=%0b exp=0", c, valid); end
      checks++; if (ack !== 16'h0000) begin failures++; $display("FAIL ill_no_ack cyc=%0d got=%h exp=0000", c, ack); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err_sticky cyc=%0d got=%0b exp=1", c, err); end
    end
    req = '0;
    step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err_hold got=%0b exp=1", err); end
    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_err_clear got=%0b exp=0", err); end
  endtask

`ifdef EVT_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    repeat (15) step();
    set_pix(1, 2'b10);
    step();
    checks++; if (addr !== 4'd1) begin failures++; $display("FAIL ts_first_addr got=%0d exp=1", addr); end
    checks++; if (ts !== 4'd15) begin failures++; $display("FAIL ts_first got=%0d exp=15", ts); end
    req = '0;
    step();
    checks++; if (ts !== 4'd15) begin failures++; $display("FAIL ts_hold got=%0d exp=15", ts); end
    set_pix(2, 2'b10);
    step();
    checks++; if (addr !== 4'd2) begin failures++; $display("FAIL ts_second_addr got=%0d exp=2", addr); end
    checks++; if (ts !== 4'd1) begin failures++; $display("FAIL ts_wrap got=%0d exp=1", ts); end
    req = '0;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req     = '0;
    ready   = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_illegal();
`ifdef EVT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
